just_pass_rtl: RTL and testbench
================================

# just_pass_rtl

Registered pass-through datapath. Each input word is delayed by a fixed, parameterised number of clock cycles and presented on `data_o`, with a companion flag `bool_o`. It is the RTL reference for the SystemC `just_pass` model. It sits beside the `just_pass_sc2sv` wrapper in the co-simulation top, and both instances must be cycle-equivalent on every output after reset.

## Interface
Parameters:
- `DATA_WIDTH`, default 8: width of the data path; legal range 1..64.
- `PIPE_DEPTH`, default 1: number of register stages (latency in cycles); legal range 1..16. Any other value is an elaboration error.

Ports:
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rstn` input, 1 bit: reset, asynchronous and active-low.
- `data_i` input, `DATA_WIDTH` bits: input sample, captured every rising edge. There is no input qualifier.
- `bool_o` output, 1 bit: output-valid flag; its meaning changes with configuration (see below).
- `data_o` output, `DATA_WIDTH` bits: delayed sample.

## Operation
- A chain of `PIPE_DEPTH` stages. Each stage holds a data word and a valid bit.
- Stage 0 loads `data_i` with valid = 1 on every rising edge while `rstn` = 1.
- Stage k loads stage k-1 (data and valid) on every rising edge.
- `data_o` is the last stage's data word, driven directly with no combinational path from `data_i`.
- Default `bool_o` is the last stage's valid bit. It reads 1 once the pipe has filled since the last reset and stays 1 until the next reset.
- There is no stall, enable or backpressure. Every cycle shifts.
- Data is passed bit-exact. There is no arithmetic, truncation or sign handling.

## Timing
- While `rstn` = 0, all stages clear asynchronously: `data_o` = 0 and `bool_o` = 0, immediately and not waiting for a clock edge.
- Latency: `data_i` sampled at edge N appears on `data_o` just after edge N+PIPE_DEPTH-1. With PIPE_DEPTH = 1 it appears after the same edge that sampled it.
- After `rstn` rises, the first rising edge with `rstn` = 1 captures.
  - `bool_o` rises after the PIPE_DEPTH-th such edge.
  - Until then `data_o` = 0.
- Reset asserted mid-stream:
  - All in-flight samples are discarded.
  - Outputs go to 0 at once.
  - Refill timing restarts from the release.
- Reset release coincident with a clock edge: that edge does not capture. The first capture is the next edge.
- Before the first reset assertion, outputs are undefined. Comparison against the SystemC model is only required after the first reset.

## Configuration
- Macro `JUST_PASS_CHANGE_DET_EN`.
- Undefined (default): `bool_o` = last-stage valid, as described above.
- Defined: `bool_o` = last-stage valid AND (`data_o` differs from the previous valid `data_o`).
  - An extra `DATA_WIDTH` register holds the previous output word and a "previous valid" bit; both clear on reset.
  - The first valid output after reset always counts as a change, so `bool_o` = 1 on that cycle.
  - Repeated identical words give `bool_o` = 0.
- The SystemC model must be built with the same setting.

## Structure
- Package `just_pass_pkg`:
  - constants `JP_DATA_WIDTH_DEF` = 8, `JP_PIPE_DEPTH_DEF` = 1, `JP_PIPE_DEPTH_MAX` = 16;
  - typedef `jp_stage_t`, a packed struct {valid, data}, sized by `DATA_WIDTH`.
- Sub-module `just_pass_stage`: one register stage with asynchronous active-low clear. The top generates `PIPE_DEPTH` instances of it.
- Top module: parameter checks, the generate chain, and the optional change detector under the macro.

## Test plan
- Reset while running: drive random data, pull `rstn` low between edges. Required: `data_o` = 0 and `bool_o` = 0 before the next edge; both stay 0 while low.
- Release with PIPE_DEPTH = 1: drive `data_i` = 0x5A on the first edge after release. Required: `data_o` = 0x5A and `bool_o` = 1 right after that edge.
- Latency with PIPE_DEPTH = 3: drive 0x01, 0x02, 0x03, 0x04 on consecutive edges. Required:
  - `data_o` shows 0x01 after the 3rd edge, then 0x02, 0x03, 0x04 on following edges;
  - `bool_o` = 0 for the first 2 edges.
- Mid-stream reset with PIPE_DEPTH = 3: assert reset with 3 words in flight, release, then drive 0xAA. Required: no pre-reset word ever appears; 0xAA appears 3 edges after release.
- Change detect with the macro defined: drive 0x10, 0x10, 0x20. Required: `bool_o` sequence 1, 0, 1 on the corresponding output cycles.
- Equivalence: 300 cycles of `$urandom` data with one reset pulse. Required: RTL and `just_pass_sc2sv` outputs match on every edge after the first reset.

Source files
------------

// File: rtl/just_pass_pkg.sv
`default_nettype none
// ============================================================================
// Module   : just_pass_pkg
// Brief    : Shared constants and stage record for the just_pass datapath.
// Revision : 1.0 - initial release
// ============================================================================
package just_pass_pkg;

  localparam int JP_DATA_WIDTH_DEF = 8;
  localparam int JP_PIPE_DEPTH_DEF = 1;
  localparam int JP_PIPE_DEPTH_MAX = 16;
  localparam int JP_DATA_WIDTH_MAX = 64;

  // Default-width stage record; the top re-declares it at its own DATA_WIDTH.
  typedef struct packed {
    logic                         valid;
    logic [JP_DATA_WIDTH_DEF-1:0] data;
  } jp_stage_t;

endpackage : just_pass_pkg
`default_nettype wire

// File: rtl/just_pass_stage.sv
`default_nettype none
// ============================================================================
// Module   : just_pass_stage
// Brief    : One pipeline register holding a {valid, data} record, async clear.
// Revision : 1.0 - initial release
// ============================================================================
module just_pass_stage
  import just_pass_pkg::*;
#(
  parameter type T = jp_stage_t
) (
  input  logic clk,
  input  logic rstn,
  input  T     i_d,
  output T     o_q
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_q <= '0;
    end else begin
      o_q <= i_d;
    end
  end

endmodule : just_pass_stage
`default_nettype wire

// File: rtl/just_pass_rtl.sv
`default_nettype none
// ============================================================================
// Module   : just_pass_rtl
// Brief    : Registered pass-through delaying data_i by PIPE_DEPTH cycles.
//            Optional change detector on bool_o: JUST_PASS_CHANGE_DET_EN.
// Revision : 1.0 - initial release
// ============================================================================
module just_pass_rtl
  import just_pass_pkg::*;
#(
  parameter int DATA_WIDTH = JP_DATA_WIDTH_DEF,
  parameter int PIPE_DEPTH = JP_PIPE_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  bool_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  typedef struct packed {
    logic                  valid;
    logic [DATA_WIDTH-1:0] data;
  } stage_t;

  if (DATA_WIDTH < 1 || DATA_WIDTH > JP_DATA_WIDTH_MAX) begin : g_bad_width
    $error("just_pass_rtl: DATA_WIDTH %0d outside 1..%0d", DATA_WIDTH, JP_DATA_WIDTH_MAX);
  end
  if (PIPE_DEPTH < 1 || PIPE_DEPTH > JP_PIPE_DEPTH_MAX) begin : g_bad_depth
    $error("just_pass_rtl: PIPE_DEPTH %0d outside 1..%0d", PIPE_DEPTH, JP_PIPE_DEPTH_MAX);
  end

  // Element 0 is the stage-0 input; element k+1 is the output of stage k.
  stage_t w_stage [PIPE_DEPTH+1];

  assign w_stage[0] = {1'b1, data_i};

  for (genvar k = 0; k < PIPE_DEPTH; k++) begin : g_stage
    just_pass_stage #(
      .T (stage_t)
    ) u_stage (
      .clk  (clk),
      .rstn (rstn),
      .i_d  (w_stage[k]),
      .o_q  (w_stage[k+1])
    );
  end

  assign data_o = w_stage[PIPE_DEPTH].data;

`ifdef JUST_PASS_CHANGE_DET_EN
  logic                  r_prev_valid;
  logic [DATA_WIDTH-1:0] r_prev_data;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_prev_valid <= 1'b0;
      r_prev_data  <= '0;
    end else if (w_stage[PIPE_DEPTH].valid) begin
      r_prev_valid <= 1'b1;
      r_prev_data  <= w_stage[PIPE_DEPTH].data;
    end
  end

  // First valid word after reset always counts as a change.
  assign bool_o = w_stage[PIPE_DEPTH].valid &
                  (~r_prev_valid | (w_stage[PIPE_DEPTH].data != r_prev_data));
`else
  assign bool_o = w_stage[PIPE_DEPTH].valid;
`endif

endmodule : just_pass_rtl
`default_nettype wire

// File: tb/tb_just_pass_rtl.sv
`default_nettype none
// ============================================================================
// Module   : tb_just_pass_rtl
// Brief    : Self-checking bench for just_pass_rtl at PIPE_DEPTH 1 and 3.
// Revision : 1.0 - initial release
// ============================================================================
module tb_just_pass_rtl;

  localparam int W = 8;

  logic         clk    = 1'b0;
  logic         rstn   = 1'b0;
  logic [W-1:0] data_i = '0;
  logic         b1, b3;
  logic [W-1:0] d1, d3;

  just_pass_rtl #(.DATA_WIDTH(W), .PIPE_DEPTH(1)) u_dut1 (
    .clk(clk), .rstn(rstn), .data_i(data_i), .bool_o(b1), .data_o(d1));
  just_pass_rtl #(.DATA_WIDTH(W), .PIPE_DEPTH(3)) u_dut3 (
    .clk(clk), .rstn(rstn), .data_i(data_i), .bool_o(b3), .data_o(d3));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: one queue of expected {valid,data} per instance.
  logic [W:0]   q1[$];
  logic [W:0]   q3[$];
  logic         pv1, pv3;
  logic [W-1:0] pd1, pd3;

  task automatic sb_reset();
    q1.delete();
    q3.delete();
    for (int i = 0; i < 2; i++) q3.push_back('0);
    pv1 = 1'b0; pv3 = 1'b0; pd1 = '0; pd3 = '0;
  endtask

  function automatic logic exp_bool(input logic [W:0] e, input logic pv, input logic [W-1:0] pd);
`ifdef JUST_PASS_CHANGE_DET_EN
    return e[W] && (!pv || (e[W-1:0] != pd));
`else
    return e[W];
`endif
  endfunction

  // Call #1 after an edge that captured din.
  task automatic sb_edge(input logic [W-1:0] din, input string tag);
    logic [W:0] e1, e3;
    q1.push_back({1'b1, din});
    q3.push_back({1'b1, din});
    e1 = q1.pop_front();
    e3 = q3.pop_front();
    check({tag, "_data1"}, 64'(d1), 64'(e1[W-1:0]));
    check({tag, "_bool1"}, 64'(b1), 64'(exp_bool(e1, pv1, pd1)));
    check({tag, "_data3"}, 64'(d3), 64'(e3[W-1:0]));
    check({tag, "_bool3"}, 64'(b3), 64'(exp_bool(e3, pv3, pd3)));
    if (e1[W]) begin pv1 = 1'b1; pd1 = e1[W-1:0]; end
    if (e3[W]) begin pv3 = 1'b1; pd3 = e3[W-1:0]; end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_data1"}, 64'(d1), 64'd0);
    check({tag, "_bool1"}, 64'(b1), 64'd0);
    check({tag, "_data3"}, 64'(d3), 64'd0);
    check({tag, "_bool3"}, 64'(b3), 64'd0);
  endtask

  // Assert reset between edges, hold across one edge, release between edges.
  task automatic do_reset(input string tag);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1 check_zero({tag, "_async"});
    @(posedge clk);
    #1 check_zero({tag, "_held"});
    #2 rstn = 1'b1;
    sb_reset();
  endtask

  typedef struct {
    logic [W-1:0] din;
    logic [W-1:0] d1;
    logic         b1;
    logic [W-1:0] d3;
    logic         b3;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{8'h5A, 8'h5A, 1'b1, 8'h00, 1'b0};
    tbl[1] = '{8'h01, 8'h01, 1'b1, 8'h00, 1'b0};
    tbl[2] = '{8'h02, 8'h02, 1'b1, 8'h5A, 1'b1};
    tbl[3] = '{8'h03, 8'h03, 1'b1, 8'h01, 1'b1};
    tbl[4] = '{8'h04, 8'h04, 1'b1, 8'h02, 1'b1};
    tbl[5] = '{8'h05, 8'h05, 1'b1, 8'h03, 1'b1};

    // Power-up reset, released between edges.
    #12;
    check_zero("por");
    rstn = 1'b1;

    // Release and latency vectors.
    for (int i = 0; i < 6; i++) begin
      data_i = tbl[i].din;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_data1", i), 64'(d1), 64'(tbl[i].d1));
      check($sformatf("vec%0d_bool1", i), 64'(b1), 64'(tbl[i].b1));
      check($sformatf("vec%0d_data3", i), 64'(d3), 64'(tbl[i].d3));
      check($sformatf("vec%0d_bool3", i), 64'(b3), 64'(tbl[i].b3));
    end

    // Mid-stream reset with three words in flight; none may resurface.
    data_i = 8'h11; @(posedge clk);
    #1 data_i = 8'h22; @(posedge clk);
    #1 data_i = 8'h33; @(posedge clk);
    #2 rstn = 1'b0;
    #1 check_zero("mid_async");
    data_i = 8'h77;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1 check_zero($sformatf("mid_held%0d", i));
    end
    #2 rstn = 1'b1;
    data_i = 8'hAA;
    @(posedge clk);
    #1;
    check("mid_e1_data1", 64'(d1), 64'hAA);
    check("mid_e1_bool1", 64'(b1), 64'd1);
    check("mid_e1_data3", 64'(d3), 64'd0);
    check("mid_e1_bool3", 64'(b3), 64'd0);
    data_i = 8'hBB;
    @(posedge clk);
    #1;
    check("mid_e2_data3", 64'(d3), 64'd0);
    check("mid_e2_bool3", 64'(b3), 64'd0);
    @(posedge clk);
    #1;
    check("mid_e3_data3", 64'(d3), 64'hAA);
    check("mid_e3_bool3", 64'(b3), 64'd1);

    // Repeated words: change-detect pattern on bool_o.
    do_reset("cd");
    begin
      logic [W-1:0] cd_seq [5];
      logic         cd_exp [3];
      cd_seq = '{8'h10, 8'h10, 8'h20, 8'h20, 8'h20};
`ifdef JUST_PASS_CHANGE_DET_EN
      cd_exp = '{1'b1, 1'b0, 1'b1};
`else
      cd_exp = '{1'b1, 1'b1, 1'b1};
`endif
      for (int i = 0; i < 5; i++) begin
        data_i = cd_seq[i];
        @(posedge clk);
        #1;
        if (i < 3) check($sformatf("cd%0d_bool1", i), 64'(b1), 64'(cd_exp[i]));
        sb_edge(cd_seq[i], $sformatf("cd%0d", i));
      end
    end

    // Random traffic against the scoreboard, with one reset pulse.
    do_reset("rnd_pre");
    for (int i = 0; i < 300; i++) begin
      if (i == 150) do_reset("rnd_mid");
      data_i = W'($urandom);
      @(posedge clk);
      #1;
      sb_edge(data_i, $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_just_pass_rtl
`default_nettype wire
